// File: rtl/matrix_scan_param_if.sv
// matrix_scan_param_if
//   Bundles the run control and panel-side signals of the HUB75 scan
//   controller.
//   master : the scan controller. It drives the column/row/bit position,
//            the active row/bit, and the clk_pixel, row_latch,
//            output_enable and frame_start strobes. It receives enable and
//            brightness.
//   slave  : the system side, meaning the control logic and the pad ring.
//            It drives enable and brightness and observes everything else.
interface matrix_scan_param_if #(
  parameter int COLUMNS   = 64,
  parameter int ROWS      = 16,
  parameter int BIT_DEPTH = 6
);
  localparam int CB = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int RB = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BB = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;

  logic          enable;
  logic [7:0]    brightness;
  logic [CB-1:0] column_address;
  logic [RB-1:0] row_address;
  logic [BB-1:0] bit_index;
  logic [RB-1:0] row_address_active;
  logic [BB-1:0] bit_index_active;
  logic          clk_pixel;
  logic          row_latch;
  logic          output_enable;
  logic          frame_start;

  modport master (
    input  enable, brightness,
    output column_address, row_address, bit_index,
    output row_address_active, bit_index_active,
    output clk_pixel, row_latch, output_enable, frame_start
  );

  modport slave (
    output enable, brightness,
    input  column_address, row_address, bit_index,
    input  row_address_active, bit_index_active,
    input  clk_pixel, row_latch, output_enable, frame_start
  );
endinterface

// File: rtl/matrix_scan_param.sv
// matrix_scan_param
//   BCM scan controller for HUB75 LED panels. The next bitplane is shifted
//   in while the previous one is displayed. All strobes come directly from
//   flops clocked by clk_in.
// Ports:
//   clk_in : system clock
//   reset  : asynchronous, active-high reset
//   bus    : matrix_scan_param_if.master. It carries enable and brightness
//            in, and carries out the position, the active plane and the
//            panel strobes.
module matrix_scan_param #(
  parameter int COLUMNS      = 64,
  parameter int ROWS         = 16,
  parameter int BIT_DEPTH    = 6,
  parameter int OE_BASE      = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                clk_in,
  input  logic                reset,
  matrix_scan_param_if.master bus
);
  localparam int CB     = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int RB     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BB     = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
  localparam int OE_MAX = OE_BASE * (2 ** (BIT_DEPTH - 1)) * 256;
  localparam int OW     = $clog2(OE_MAX + 1);
  localparam int KW     = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT, WAIT, BLANK, LATCH} state_t;

  // Display length of one plane:
  //   ((OE_BASE << bit) * (brightness + 1)) >> 8
  function automatic logic [OW-1:0] oe_len(input logic [BB-1:0] b,
                                           input logic [7:0]    br);
    logic [OW+8:0] prod;
    prod = ((OW+9)'(OE_BASE) << b) * (OW+9)'({1'b0, br} + 9'd1);
    return prod[OW+7:8];
  endfunction

  state_t        state, state_d;
  logic          phase, phase_d;
  logic [CB-1:0] col, col_d;
  logic [RB-1:0] row, row_d, row_act, row_act_d;
  logic [BB-1:0] bitx, bit_d, bit_act, bit_act_d;
  logic [OW-1:0] oe_cnt, oe_cnt_d;
  logic [KW-1:0] blank_cnt, blank_d;
  logic          cp_q, cp_d, latch_q, latch_d, oe_q, oe_d, fs_q, fs_d;
  state_t        drained;

  always_comb begin
    state_d   = state;
    phase_d   = phase;
    col_d     = col;
    row_d     = row;
    bit_d     = bitx;
    row_act_d = row_act;
    bit_act_d = bit_act;
    blank_d   = blank_cnt;
    // The OE countdown runs in every state. It is reloaded only at LATCH.
    oe_cnt_d  = (oe_cnt != '0) ? oe_cnt - OW'(1) : '0;
    // Once shifting is done and OE has drained, go to the dead time, or
    // go straight to the latch when there is no dead time.
    drained   = (BLANK_CYCLES > 0) ? BLANK : LATCH;

    case (state)
      IDLE: begin
        if (bus.enable) begin
          state_d = SHIFT;
          phase_d = 1'b0;
          col_d   = '0;
        end
      end
      SHIFT: begin
        if (!phase) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (col == CB'(COLUMNS - 1)) begin
            // Decide on the counter value of the next cycle. That way BLANK
            // starts on the first cycle with OE low, and WAIT takes no
            // cycles when OE has already finished.
            state_d = (oe_cnt_d != '0) ? WAIT : drained;
            blank_d = '0;
          end else begin
            col_d = col + CB'(1);
          end
        end
      end
      WAIT: begin
        if (oe_cnt_d == '0) begin
          state_d = drained;
          blank_d = '0;
        end
      end
      BLANK: begin
        if (blank_cnt == KW'(BLANK_CYCLES - 1)) state_d = LATCH;
        else                                    blank_d = blank_cnt + KW'(1);
      end
      LATCH: begin
        row_act_d = row;
        bit_act_d = bitx;
        oe_cnt_d  = oe_len(bitx, bus.brightness);
        if (bitx == BB'(BIT_DEPTH - 1)) begin
          bit_d = '0;
          row_d = (row == RB'(ROWS - 1)) ? '0 : row + RB'(1);
        end else begin
          bit_d = bitx + BB'(1);
        end
        if (bus.enable) begin
          state_d = SHIFT;
          phase_d = 1'b0;
          col_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Each strobe is registered from the next-state values, so the strobe
    // lines up with the state it describes.
    cp_d    = (state_d == SHIFT) && phase_d;
    latch_d = (state_d == LATCH);
    oe_d    = (oe_cnt_d != '0);
    fs_d    = (state_d == SHIFT) && (state != SHIFT) &&
              (row_d == '0) && (bit_d == '0);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= 1'b0;
      col       <= '0;
      row       <= '0;
      bitx      <= '0;
      row_act   <= '0;
      bit_act   <= '0;
      oe_cnt    <= '0;
      blank_cnt <= '0;
      cp_q      <= 1'b0;
      latch_q   <= 1'b0;
      oe_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      col       <= col_d;
      row       <= row_d;
      bitx      <= bit_d;
      row_act   <= row_act_d;
      bit_act   <= bit_act_d;
      oe_cnt    <= oe_cnt_d;
      blank_cnt <= blank_d;
      cp_q      <= cp_d;
      latch_q   <= latch_d;
      oe_q      <= oe_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.column_address     = col;
  assign bus.row_address        = row;
  assign bus.bit_index          = bitx;
  assign bus.row_address_active = row_act;
  assign bus.bit_index_active   = bit_act;
  assign bus.clk_pixel          = cp_q;
  assign bus.row_latch          = latch_q;
  assign bus.output_enable      = oe_q;
  assign bus.frame_start        = fs_q;
endmodule

// File: tb/tb_matrix_scan_param.sv
// tb_matrix_scan_param
//   Directed bench for matrix_scan_param. dut_a uses the default geometry
//   with OE_BASE=4. dut_b uses OE_BASE=8. Both share the clock, reset,
//   enable and brightness. Expected values are worked out by hand from the
//   plane timing:
//     period = max(2*COLUMNS, N) + BLANK_CYCLES + 1
`timescale 1ns/1ps
module tb_matrix_scan_param;
  logic       clk_in = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] bright;
  logic       sel;

  always #5 clk_in = ~clk_in;

  matrix_scan_param_if #(.COLUMNS(64), .ROWS(16), .BIT_DEPTH(6)) ifa ();
  matrix_scan_param_if #(.COLUMNS(64), .ROWS(16), .BIT_DEPTH(6)) ifb ();

  assign ifa.enable     = en;
  assign ifa.brightness = bright;
  assign ifb.enable     = en;
  assign ifb.brightness = bright;

  matrix_scan_param #(.COLUMNS(64), .ROWS(16), .BIT_DEPTH(6),
                      .OE_BASE(4), .BLANK_CYCLES(2))
    dut_a (.clk_in(clk_in), .reset(reset), .bus(ifa));

  matrix_scan_param #(.COLUMNS(64), .ROWS(16), .BIT_DEPTH(6),
                      .OE_BASE(8), .BLANK_CYCLES(2))
    dut_b (.clk_in(clk_in), .reset(reset), .bus(ifb));

  // The plane-measuring tasks look at whichever DUT sel picks.
  logic       s_cp, s_latch, s_oe;
  logic [3:0] s_rowa;
  logic [2:0] s_bita;
  always_comb begin
    if (sel) begin
      s_cp = ifb.clk_pixel; s_latch = ifb.row_latch; s_oe = ifb.output_enable;
      s_rowa = ifb.row_address_active; s_bita = ifb.bit_index_active;
    end else begin
      s_cp = ifa.clk_pixel; s_latch = ifa.row_latch; s_oe = ifa.output_enable;
      s_rowa = ifa.row_address_active; s_bita = ifa.bit_index_active;
    end
  end

  logic [23:0] outs_a;
  assign outs_a = {ifa.column_address, ifa.row_address, ifa.bit_index,
                   ifa.row_address_active, ifa.bit_index_active,
                   ifa.clk_pixel, ifa.row_latch, ifa.output_enable,
                   ifa.frame_start};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle stamps and invariant monitor for dut_a
  int         cyc = 0;
  int         fs_prev = 0, fs_last = 0;
  int         viol = 0;
  logic       prev_latch = 1'b0;
  logic [3:0] prev_rowa = '0;

  always @(negedge clk_in) begin
    cyc <= cyc + 1;
    if (!reset && ifa.frame_start) begin
      fs_prev <= fs_last;
      fs_last <= cyc;
    end
    if (!reset && ((ifa.row_latch && ifa.output_enable) ||
                   (ifa.row_latch && ifa.clk_pixel) ||
                   ((ifa.row_address_active != prev_rowa) && !prev_latch)))
      viol <= viol + 1;
    prev_latch <= ifa.row_latch;
    prev_rowa  <= ifa.row_address_active;
  end

  // Call this on the negedge where row_latch is high. It measures the plane
  // that this latch just made active, up to and including the next latch.
  task automatic measure_plane(output int gap, output int oe_len,
                               output int oe_first, output int overlap,
                               output logic [3:0] rowa,
                               output logic [2:0] bita);
    gap = 0; oe_len = 0; oe_first = 0; overlap = 0; rowa = '0; bita = '0;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk_in);
      if (n == 1) begin rowa = s_rowa; bita = s_bita; end
      if (s_oe) begin
        oe_len++;
        if (oe_first == 0) oe_first = n;
      end
      if (s_oe && s_latch) overlap++;
      if (s_latch) begin gap = n; break; end
    end
    if (gap == 0) check("plane_timeout", 0, 1);
  endtask

  task automatic wait_latch(output int k);
    k = 0;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk_in);
      if (s_latch) begin k = n; break; end
    end
    if (k == 0) check("latch_timeout", 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, gap, oe_len, oe_first, overlap;
    int pulses, col_err, last_pulse, latch_k, fs_k, act_err, gap_err, cnt, ovl;
    logic [3:0] rowa;
    logic [2:0] bita;

    sel = 1'b0; en = 1'b0; bright = 8'd255; reset = 1'b1;
    repeat (3) @(negedge clk_in);
    check("reset_outputs_a", outs_a, 0);
    check("reset_oe_b", ifb.output_enable, 0);

    // First plane from reset with enable=1 and full brightness
    en = 1'b1;
    reset = 1'b0;
    pulses = 0; col_err = 0; last_pulse = 0; latch_k = 0; fs_k = 0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk_in);
      if (ifa.frame_start && fs_k == 0) fs_k = n;
      if (ifa.clk_pixel) begin
        if (int'(ifa.column_address) != pulses) col_err++;
        pulses++;
        last_pulse = n;
      end
      if (ifa.row_latch) begin latch_k = n; break; end
    end
    check("first_pulses", pulses, 64);
    check("first_col_order", col_err, 0);
    check("first_frame_start", fs_k, 1);
    check("first_latch_cycle", latch_k, 131);
    check("blank_gap", latch_k - last_pulse, 3);

    // One full frame plus one plane, so row_address_active wraps to 0
    act_err = 0; gap_err = 0;
    for (int p = 0; p <= 96; p++) begin
      measure_plane(gap, oe_len, oe_first, overlap, rowa, bita);
      if (p == 0) check("first_oe_start", oe_first, 1);
      if (p < 6) begin
        check($sformatf("oe_b255_bit%0d", p), oe_len, 4 << p);
        check($sformatf("gap_b255_bit%0d", p), gap, 131);
      end
      if (gap != 131) gap_err++;
      if (rowa != 4'((p / 6) % 16) || bita != 3'(p % 6)) act_err++;
    end
    check("frame_gap_errors", gap_err, 0);
    check("active_sequence", act_err, 0);
    check("frame_start_spacing", fs_last - fs_prev, 12576);

    // Drop enable mid-SHIFT while plane 98 is being shifted
    repeat (20) @(negedge clk_in);
    en = 1'b0;
    wait_latch(k);
    check("drop_latch_delay", k, 111);
    @(negedge clk_in);
    check("drop_bit_active", ifa.bit_index_active, 2);
    check("drop_next_bit", ifa.bit_index, 3);
    check("drop_next_row", ifa.row_address, 0);
    cnt = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_in);
      if (ifa.clk_pixel || ifa.row_latch || ifa.frame_start) cnt++;
    end
    check("idle_strobes", cnt, 0);
    en = 1'b1;
    k = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_in);
      if (ifa.clk_pixel) begin k = n; break; end
    end
    check("resume_delay", k, 2);
    check("resume_bit", ifa.bit_index, 3);
    check("resume_col", ifa.column_address, 0);

    // Reset mid-OE (plane 99 is bit 3, N=32)
    wait_latch(k);
    repeat (3) @(negedge clk_in);
    check("oe_before_reset", ifa.output_enable, 1);
    #2 reset = 1'b1;
    #1 check("reset_mid_oe", outs_a, 0);

    // Brightness 127
    @(negedge clk_in);
    bright = 8'd127;
    reset = 1'b0;
    wait_latch(k);
    for (int p = 0; p < 6; p++) begin
      measure_plane(gap, oe_len, oe_first, overlap, rowa, bita);
      check($sformatf("oe_b127_bit%0d", p), oe_len, 2 << p);
    end

    // Brightness 0 with bit 0 gives N=0
    reset = 1'b1;
    @(negedge clk_in);
    bright = 8'd0;
    reset = 1'b0;
    wait_latch(k);
    measure_plane(gap, oe_len, oe_first, overlap, rowa, bita);
    check("oe_b0_bit0", oe_len, 0);
    check("gap_b0_bit0", gap, 131);

    // dut_b with OE_BASE=8: plane 5 runs longer than shifting and stretches WAIT
    reset = 1'b1;
    @(negedge clk_in);
    bright = 8'd255;
    sel = 1'b1;
    reset = 1'b0;
    wait_latch(k);
    ovl = 0;
    for (int p = 0; p < 6; p++) begin
      measure_plane(gap, oe_len, oe_first, overlap, rowa, bita);
      ovl += overlap;
      check($sformatf("oe_base8_bit%0d", p), oe_len, 8 << p);
      check($sformatf("gap_base8_bit%0d", p), gap,
            ((8 << p) > 128) ? (8 << p) + 3 : 131);
    end
    check("base8_overlap", ovl, 0);

    check("invariants_a", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_scan_param.md
Name: matrix_scan_param

Overview:
Parametrised HUB75-style scan controller for binary-coded-modulation (BCM) LED matrix panels. Generalises the fixed 64-column / 16-row / 6-bit scanner with configurable geometry and bit depth, global brightness scaling of the output-enable period, anti-ghost blanking and a run/stop control. All panel strobes are registered in the single clk_in domain; no gated clocks. It sits between the framebuffer read port and the panel pins. Shifting of the next bitplane overlaps display of the previous one.

Parameters:
COLUMNS, 64, pixels shifted per row-plane; must be ≥ 2.
ROWS, 16, row addresses; row_address width RB = clog2(ROWS), minimum 1.
BIT_DEPTH, 6, bitplanes per row; bit_index width BB = clog2(BIT_DEPTH), minimum 1.
OE_BASE, 4, output-enable cycles for bit 0 at full brightness.
BLANK_CYCLES, 2, dead cycles between output_enable low and row_latch; 0 is allowed.

Ports:
clk_in  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run request
brightness  in  8  global brightness, sampled at latch
column_address  out  clog2(COLUMNS)  column being shifted
row_address  out  RB  row being shifted
bit_index  out  BB  bitplane being shifted
row_address_active  out  RB  row currently displayed
bit_index_active  out  BB  bitplane currently displayed
clk_pixel  out  1  panel shift clock
row_latch  out  1  panel latch strobe
output_enable  out  1  LEDs on, active-high; the pad inverts it
frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset (async, active-high): state IDLE; every output 0; OE counter 0.
- FSM states: IDLE, SHIFT, WAIT, BLANK, LATCH.
- IDLE: if enable=1, go to SHIFT on the next cycle. Position (row/bit) is retained, not reset.
- SHIFT: 2 cycles per column, columns ascending 0..COLUMNS-1.
  - Phase 0: column_address updated, clk_pixel=0.
  - Phase 1: clk_pixel=1.
  - Framebuffer data for (row_address, bit_index, column_address) has exactly one cycle of latency to the clk_pixel rising edge.
  - After the last phase 1, go to WAIT.
- WAIT: hold while OE counter ≠ 0. Then go to BLANK, or straight to LATCH if BLANK_CYCLES=0.
- BLANK: output_enable=0 for BLANK_CYCLES cycles, then LATCH.
- LATCH: row_latch=1 for exactly one cycle. On the same edge:
  - row_address_active ← row_address; bit_index_active ← bit_index.
  - OE counter ← N = ((OE_BASE << bit_index) × (brightness + 1)) >> 8. Counter width is sized for OE_BASE × 2^(BIT_DEPTH-1) × 256.
  - Advance position: bit_index+1. On bit_index = BIT_DEPTH-1, bit_index ← 0 and row_address+1. On row ROWS-1, row wraps to 0.
  - Next state: SHIFT if enable=1, else IDLE.
- output_enable = (OE counter ≠ 0). It asserts the cycle after LATCH, lasts exactly N cycles, and the counter decrements every cycle in any state. N=0 means the plane is not displayed.
- Plane period = max(2×COLUMNS, N) + BLANK_CYCLES + 1 cycles. A long OE stretches WAIT, never truncates.
- frame_start: one-cycle pulse on the first SHIFT cycle in which row_address=0 and bit_index=0, including the first frame after reset.
- enable deasserted mid-plane: the current plane completes through LATCH, then IDLE. The OE countdown finishes normally. Re-enable resumes at the retained position.
- Invariants:
  - row_latch and output_enable are never high in the same cycle.
  - clk_pixel is low outside SHIFT.
  - row_address_active changes only at LATCH.
- Reset mid-operation: all outputs go low immediately, asynchronously.

Test Plan:
- Defaults, enable=1, brightness=255 from reset:
  - 64 clk_pixel pulses, column_address 0..63, then BLANK (2 cycles), then row_latch.
  - First OE is 4 cycles; the next latch follows at 131-cycle spacing.
- Defaults, brightness=255, bit_index_active=5: output_enable high for 128 cycles; the next row_latch comes exactly 131 cycles after the previous one.
- OE_BASE=8, brightness=255: the bit-5 plane gives 256 OE cycles; the next row_latch comes 256+2+1 cycles after the previous one, with no overlap with output_enable.
- Defaults, brightness=127: OE lengths for bits 0..5 are 2, 4, 8, 16, 32, 64. Brightness=0 with bit 0 gives N=0, so output_enable stays low.
- Defaults, brightness=255: frame_start pulses are 96×131 = 12576 cycles apart; row_address_active steps 0..15 and wraps to 0.
- Invariants and control:
  - Drop enable mid-SHIFT: the latch still occurs, then IDLE with all strobes low; on re-enable, shifting resumes at the next plane.
  - Assert reset mid-OE: all outputs are 0 at once.
